// File: rtl/load_align_unit_if.sv
// Load request / memory read / response signal bundle for load_align_unit.
// The slave modport is the unit's view; the master modport is the CPU-plus-memory side.
interface load_align_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic        mem_rd_ack;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_ale;
  logic        rsp_err;

  modport slave (
    input  req_valid, req_op, req_addr, mem_rd_ack, mem_rdata, rsp_ready,
    output req_ready, mem_rd_en, mem_addr, rsp_valid, rsp_data, rsp_ale, rsp_err
  );

  modport master (
    output req_valid, req_op, req_addr, mem_rd_ack, mem_rdata, rsp_ready,
    input  req_ready, mem_rd_en, mem_addr, rsp_valid, rsp_data, rsp_ale, rsp_err
  );
endinterface

// File: rtl/load_align_unit.sv
// Single-outstanding load unit: alignment check, word read with timeout,
// byte/half lane extraction with sign/zero extension, held response.
module load_align_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic           cpu_clk,
  input logic           cpu_rstn,
  load_align_unit_if.slave bus
);
  localparam logic [7:0] TO = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, READ, RESP} state_e;

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        ale_q, ale_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        bad_req;
  logic [31:0] shifted;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] ext;

  // Illegal opcodes are folded into the misalign error path.
  always_comb begin
    bad_req = 1'b0;
    case (bus.req_op)
      3'd1, 3'd5:       bad_req = bus.req_addr[0];
      3'd2:             bad_req = |bus.req_addr[1:0];
      3'd3, 3'd6, 3'd7: bad_req = 1'b1;
      default:          bad_req = 1'b0;
    endcase
  end

  always_comb begin
    shifted = bus.mem_rdata >> {addr_q[1:0], 3'b000};
    byte_v  = shifted[7:0];
    half_v  = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (op_q)
      3'd0:    ext = {{24{byte_v[7]}}, byte_v};
      3'd4:    ext = {24'd0, byte_v};
      3'd1:    ext = {{16{half_v[15]}}, half_v};
      3'd5:    ext = {16'd0, half_v};
      default: ext = bus.mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    data_d  = data_q;
    ale_d   = ale_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        op_d   = bus.req_op;
        addr_d = bus.req_addr;
        cnt_d  = 8'd0;
        if (bad_req) begin
          state_d = RESP;
          data_d  = 32'd0;
          ale_d   = 1'b1;
          err_d   = 1'b0;
        end else begin
          state_d = READ;
        end
      end
      READ: begin
        // An ack on the timeout cycle still delivers data.
        if (bus.mem_rd_ack) begin
          state_d = RESP;
          data_d  = ext;
          ale_d   = 1'b0;
          err_d   = 1'b0;
        end else if (cnt_q + 8'd1 == TO) begin
          state_d = RESP;
          data_d  = 32'd0;
          ale_d   = 1'b0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state_q <= IDLE;
      op_q    <= 3'd0;
      addr_q  <= 32'd0;
      data_q  <= 32'd0;
      ale_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ale_q   <= ale_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.mem_rd_en = (state_q == READ);
  assign bus.mem_addr  = bus.mem_rd_en ? {addr_q[31:2], 2'b00} : 32'd0;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_data  = bus.rsp_valid ? data_q : 32'd0;
  assign bus.rsp_ale   = bus.rsp_valid & ale_q;
  assign bus.rsp_err   = bus.rsp_valid & err_q;
endmodule

// File: tb/tb_load_align_unit.sv
// Scoreboard bench for load_align_unit: directed loads push expected
// responses; a negedge monitor pops and compares on each response handshake.
module tb_load_align_unit;
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  load_align_unit_if bus();

  load_align_unit #(.TIMEOUT(4)) dut (
    .cpu_clk (clk),
    .cpu_rstn(rstn),
    .bus     (bus.slave)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        ale;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got data %h, expected no response", bus.rsp_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rsp_data", bus.rsp_data, mon_e.data);
          chk("rsp_ale", {31'd0, bus.rsp_ale}, {31'd0, mon_e.ale});
          chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, mon_e.err});
        end
      end
      if (!bus.rsp_valid)
        chk("flags_idle", {30'd0, bus.rsp_ale, bus.rsp_err}, 32'd0);
    end
  end

  // ack_at: READ-cycle index (0-based) on which to ack, -1 for none.
  task automatic do_load(input logic [2:0] op, input logic [31:0] addr, input int ack_at,
                         input logic [31:0] rdata, input logic [31:0] exp_data,
                         input logic exp_ale, input logic exp_err, input int exp_lat,
                         input int hold);
    int   cyc;
    rsp_t r;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    chk("req_ready_idle", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    r.data = exp_data; r.ale = exp_ale; r.err = exp_err;
    exp_q.push_back(r);
    if (exp_ale) begin
      chk("rd_en_ale", {31'd0, bus.mem_rd_en}, 32'd0);
    end else begin
      chk("rd_en", {31'd0, bus.mem_rd_en}, 32'd1);
      chk("mem_addr", bus.mem_addr, {addr[31:2], 2'b00});
    end
    cyc = 0;
    while (!bus.rsp_valid && cyc < 40) begin
      if (cyc > 0) chk("mem_addr_hold", bus.mem_addr, {addr[31:2], 2'b00});
      bus.mem_rd_ack = (cyc == ack_at);
      bus.mem_rdata  = rdata;
      @(posedge clk); #1;
      bus.mem_rd_ack = 1'b0;
      cyc++;
    end
    chk("rsp_latency", cyc, exp_lat);
    chk("req_ready_resp", {31'd0, bus.req_ready}, 32'd0);
    chk("rd_en_off", {31'd0, bus.mem_rd_en}, 32'd0);
    for (int h = 0; h < hold; h++) begin
      chk("hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("hold_data", bus.rsp_data, exp_data);
      chk("hold_ready", {31'd0, bus.req_ready}, 32'd0);
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk("idle_after_hs", {31'd0, bus.req_ready}, 32'd1);
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_op     = 3'd0;
    bus.req_addr   = 32'd0;
    bus.mem_rd_ack = 1'b0;
    bus.mem_rdata  = 32'd0;
    bus.rsp_ready  = 1'b0;
    #12;
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_rd_en", {31'd0, bus.mem_rd_en}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_data", bus.rsp_data, 32'd0);
    chk("rst_flags", {30'd0, bus.rsp_ale, bus.rsp_err}, 32'd0);
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;

    // op, addr, ack_at, rdata, exp_data, ale, err, latency, hold
    do_load(3'd0, 32'h0000_1003, 2,  32'h80FF_1234, 32'hFFFF_FF80, 1'b0, 1'b0, 3, 0);
    do_load(3'd5, 32'h0000_2002, 0,  32'h8001_0000, 32'h0000_8001, 1'b0, 1'b0, 1, 0);
    do_load(3'd1, 32'h0000_2002, 1,  32'h8001_0000, 32'hFFFF_8001, 1'b0, 1'b0, 2, 0);
    do_load(3'd4, 32'h0000_1001, 0,  32'h80FF_1234, 32'h0000_0012, 1'b0, 1'b0, 1, 0);
    do_load(3'd4, 32'h0000_1002, 0,  32'h80FF_1234, 32'h0000_00FF, 1'b0, 1'b0, 1, 0);
    do_load(3'd0, 32'h0000_1002, 0,  32'h80FF_1234, 32'hFFFF_FFFF, 1'b0, 1'b0, 1, 0);
    do_load(3'd1, 32'h0000_1000, 0,  32'h80FF_9234, 32'hFFFF_9234, 1'b0, 1'b0, 1, 0);
    do_load(3'd2, 32'h0000_3000, 0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0, 1, 3);
    do_load(3'd2, 32'h0000_3001, -1, 32'h0,         32'h0,         1'b1, 1'b0, 0, 0);
    do_load(3'd3, 32'h0000_3000, -1, 32'h0,         32'h0,         1'b1, 1'b0, 0, 0);
    do_load(3'd6, 32'h0000_3000, -1, 32'h0,         32'h0,         1'b1, 1'b0, 0, 0);
    do_load(3'd1, 32'h0000_2001, -1, 32'h0,         32'h0,         1'b1, 1'b0, 0, 0);
    do_load(3'd5, 32'h0000_2003, -1, 32'h0,         32'h0,         1'b1, 1'b0, 0, 2);
    do_load(3'd2, 32'h0000_4000, -1, 32'h1234_5678, 32'h0,         1'b0, 1'b1, 4, 0);
    do_load(3'd2, 32'h0000_4000, 3,  32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0, 4, 0);

    // Reset during READ: the late ack must produce nothing.
    bus.req_valid = 1'b1; bus.req_op = 3'd2; bus.req_addr = 32'h0000_5000;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("abort_rd_en", {31'd0, bus.mem_rd_en}, 32'd1);
    @(posedge clk); #1;
    rstn = 1'b0;
    #2;
    chk("abort_rd_en_rst", {31'd0, bus.mem_rd_en}, 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    bus.mem_rd_ack = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    bus.mem_rd_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("abort_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
      chk("abort_idle", {31'd0, bus.req_ready}, 32'd1);
      @(posedge clk); #1;
    end
    do_load(3'd4, 32'h0000_6003, 1, 32'hA5B6_C7D8, 32'h0000_00A5, 1'b0, 1'b0, 2, 0);

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL leftover_rsp: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
